// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit XNOR LFSR generator/checker pair.
// Holds the checker state encoding, LFSR width, tap positions, the XNOR
// lockup pattern and the next-bit function used by both the generator and
// the checker, so they can never disagree on the polynomial.
package lfsr_pkg;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int LFSR_W = 4;
    localparam int TAP_HI = 3;
    localparam int TAP_LO = 2;

    // All-ones is the stuck state of an XNOR LFSR.
    localparam logic [LFSR_W-1:0] LOCKUP = 4'b1111;

    // Bit that follows history s (s[0] newest).
    function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] s);
        return ~(s[TAP_HI] ^ s[TAP_LO]);
    endfunction

endpackage

// File: rtl/lfsr_err_window.sv
// Error window tracker for the locked checker.
// Counts locked beats in a window of WINDOW beats and the mismatches seen
// inside it; flags when the error count of the current window would reach
// ERR_LIMIT.
//   clk, reset  : clock, async active-high reset
//   clear       : hold counters at zero (checker not locked)
//   beat        : one valid beat while locked
//   miss        : that beat mismatched the prediction
//   limit_hit   : combinational; this beat brings the window to ERR_LIMIT
module lfsr_err_window #(
    parameter int WINDOW    = 16,
    parameter int ERR_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic beat,
    input  logic miss,
    output logic limit_hit
);
    localparam int BW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(ERR_LIMIT + 1);

    logic [BW-1:0] beat_cnt;
    logic [EW-1:0] err_cnt, err_base, err_nx;
    logic          wrap;

    // On the wrap beat the old window is discarded first, so a mismatch on
    // that beat becomes the first error of the new window.
    assign wrap      = (beat_cnt == BW'(WINDOW - 1));
    assign err_base  = wrap ? '0 : err_cnt;
    assign err_nx    = err_base + EW'(miss);
    assign limit_hit = beat && miss && (err_nx == EW'(ERR_LIMIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
            err_cnt  <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
            err_cnt  <= '0;
        end else if (beat) begin
            beat_cnt <= wrap ? '0 : beat_cnt + BW'(1);
            err_cnt  <= err_nx;
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Serial checker for a 4-bit XNOR LFSR stream.
// FILL loads four bits of history, SEARCH requires LOCK_CNT consecutive
// correct predictions, LOCKED free-runs the local LFSR and counts mismatches;
// ERR_LIMIT mismatches inside one WINDOW-beat window drop back to FILL.
//   clk, reset : clock, async active-high reset
//   din_valid  : qualifies din; nothing advances without it
//   din        : serial bit under test
//   clear_err  : synchronous clear of err_count (independent of din_valid)
//   locked     : high while LOCKED
//   err_pulse  : one cycle per mismatch while locked
//   lock_lost  : one cycle on LOCKED -> FILL
//   err_count  : saturating mismatch count, survives loss of lock
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT  = 8,
    parameter int ERR_LIMIT = 4,
    parameter int WINDOW    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din_valid,
    input  logic       din,
    input  logic       clear_err,
    output logic       locked,
    output logic       err_pulse,
    output logic       lock_lost,
    output logic [7:0] err_count
);
    localparam int MW = $clog2(LOCK_CNT + 1);

    logic [1:0]        state, state_nx;
    logic [LFSR_W-1:0] sr, sr_nx, sr_din;
    logic [1:0]        fill_cnt, fill_nx;
    logic [MW-1:0]     match_cnt, match_nx;
    logic              pred, in_lock, miss, limit_hit;

    assign pred    = lfsr_next_bit(sr);
    assign sr_din  = {sr[LFSR_W-2:0], din};
    assign in_lock = (state == ST_LOCKED);
    assign miss    = din_valid && in_lock && (din != pred);

    lfsr_err_window #(
        .WINDOW   (WINDOW),
        .ERR_LIMIT(ERR_LIMIT)
    ) u_win (
        .clk      (clk),
        .reset    (reset),
        .clear    (!in_lock),
        .beat     (din_valid && in_lock),
        .miss     (miss),
        .limit_hit(limit_hit)
    );

    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        fill_nx  = fill_cnt;
        match_nx = match_cnt;
        if (din_valid) begin
            case (state)
                ST_FILL: begin
                    sr_nx   = sr_din;
                    fill_nx = fill_cnt + 2'd1;
                    if (fill_cnt == 2'd3) begin
                        state_nx = ST_SEARCH;
                        match_nx = '0;
                    end
                end
                ST_SEARCH: begin
                    sr_nx = sr_din;
                    // Landing in the lockup pattern can never be a real
                    // sequence, so it breaks the run even if the bit matched.
                    if (din == pred && sr_din != LOCKUP) begin
                        if (match_cnt == MW'(LOCK_CNT - 1)) begin
                            state_nx = ST_LOCKED;
                            match_nx = '0;
                        end else begin
                            match_nx = match_cnt + MW'(1);
                        end
                    end else begin
                        match_nx = '0;
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction so one corrupted input bit
                    // is reported once instead of poisoning the history.
                    sr_nx = {sr[LFSR_W-2:0], pred};
                    if (limit_hit) begin
                        state_nx = ST_FILL;
                        fill_nx  = '0;
                    end
                end
                default: state_nx = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_FILL;
            sr        <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            sr        <= sr_nx;
            fill_cnt  <= fill_nx;
            match_cnt <= match_nx;
            locked    <= (state_nx == ST_LOCKED);
            err_pulse <= miss;
            lock_lost <= limit_hit;
            if (clear_err)
                err_count <= {7'd0, miss};
            else if (miss && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model built on a bit-history
// queue and beat indices since lock.
module tb_lfsr_checker;
    localparam int LOCK_CNT  = 8;
    localparam int ERR_LIMIT = 4;
    localparam int WINDOW    = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;
    logic       clear_err = 1'b0;
    logic       locked, err_pulse, lock_lost;
    logic [7:0] err_count;

    lfsr_checker #(
        .LOCK_CNT (LOCK_CNT),
        .ERR_LIMIT(ERR_LIMIT),
        .WINDOW   (WINDOW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din_valid(din_valid),
        .din      (din),
        .clear_err(clear_err),
        .locked   (locked),
        .err_pulse(err_pulse),
        .lock_lost(lock_lost),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int n_pulse = 0, n_lost = 0, n_lockseen = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_FILL, M_SEARCH, M_LOCKED} mode_t;
    mode_t m_mode = M_FILL;
    bit    hq[$] = '{0, 0, 0, 0};   // hq[0] = bit four beats ago, hq[3] = newest
    int    m_fill = 0, m_run = 0, m_k = 0, m_win = 0, m_werr = 0, m_cnt = 0;
    bit    e_locked = 0, e_pulse = 0, e_lost = 0;

    always @(posedge clk or posedge reset) begin
        bit p, miss;
        if (reset) begin
            m_mode = M_FILL; hq = '{0, 0, 0, 0};
            m_fill = 0; m_run = 0; m_k = 0; m_win = 0; m_werr = 0; m_cnt = 0;
            e_locked = 0; e_pulse = 0; e_lost = 0;
        end else begin
            miss = 0; e_pulse = 0; e_lost = 0;
            if (din_valid) begin
                p = !(hq[0] ^ hq[1]);
                case (m_mode)
                    M_FILL: begin
                        hq.push_back(din); void'(hq.pop_front());
                        m_fill++;
                        if (m_fill == 4) begin m_mode = M_SEARCH; m_run = 0; end
                    end
                    M_SEARCH: begin
                        hq.push_back(din); void'(hq.pop_front());
                        if (din == p && !(hq[0] && hq[1] && hq[2] && hq[3])) m_run++;
                        else m_run = 0;
                        if (m_run == LOCK_CNT) begin
                            m_mode = M_LOCKED; m_k = 0; m_win = 0; m_werr = 0;
                        end
                    end
                    default: begin
                        miss = (din != p);
                        hq.push_back(p); void'(hq.pop_front());
                        // beat k belongs to window (k+1)/WINDOW: the last beat
                        // of a window already counts toward the next one
                        if ((m_k + 1) / WINDOW != m_win) begin
                            m_win = (m_k + 1) / WINDOW; m_werr = 0;
                        end
                        m_k++;
                        if (miss) begin
                            e_pulse = 1; m_werr++;
                            if (m_cnt < 255) m_cnt++;
                            if (m_werr == ERR_LIMIT) begin
                                m_mode = M_FILL; m_fill = 0; e_lost = 1;
                            end
                        end
                    end
                endcase
            end
            if (clear_err) m_cnt = miss ? 1 : 0;
            e_locked = (m_mode == M_LOCKED);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("locked", 32'(locked), 32'(e_locked));
        check("err_pulse", 32'(err_pulse), 32'(e_pulse));
        check("lock_lost", 32'(lock_lost), 32'(e_lost));
        check("err_count", 32'(err_count), 32'(m_cnt));
        if (err_pulse === 1'b1) n_pulse++;
        if (lock_lost === 1'b1) n_lost++;
        if (locked === 1'b1) n_lockseen++;
    end

    // ---------------- stimulus ----------------
    bit gen[15];
    int sidx = 0;

    task automatic raw(input bit v, input bit d, input bit clr);
        din_valid = v; din = d; clear_err = clr;
        @(posedge clk); #1;
        din_valid = 0; clear_err = 0;
    endtask

    task automatic step(input bit v, input bit flip, input bit clr);
        bit d;
        d = v ? (gen[sidx] ^ flip) : 1'($urandom);
        raw(v, d, clr);
        if (v) sidx = (sidx + 1) % 15;
    endtask

    task automatic do_reset();
        reset = 1;
        raw(0, 0, 0);
        raw(0, 0, 0);
        reset = 0;
        sidx = 0;
    endtask

    task automatic wait_lock(input string nm);
        for (int i = 0; i < 100 && !e_locked; i++) step(1, 0, 0);
        check(nm, 32'(locked), 32'd1);
    endtask

    initial begin
        int p0, l0, s0, flips;
        bit seq[15] = '{1,1,1,0,1,1,0,0,1,0,1,0,0,0,0};
        gen = seq;

        // reset state
        do_reset();
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_pulses", 32'(err_pulse | lock_lost), 32'd0);

        // clean stream: lock on the 12th beat, no errors over 100 beats
        for (int i = 0; i < 11; i++) step(1, 0, 0);
        check("lock_early", 32'(locked), 32'd0);
        step(1, 0, 0);
        check("lock_at_12", 32'(locked), 32'd1);
        for (int i = 0; i < 88; i++) step(1, 0, 0);
        check("clean_err_count", 32'(err_count), 32'd0);

        // single inverted bit
        p0 = n_pulse; l0 = n_lost;
        step(1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        check("single_err_count", 32'(err_count), 32'd1);
        check("single_locked", 32'(locked), 32'd1);
        check("single_pulses", 32'(n_pulse - p0), 32'd1);
        check("single_no_lost", 32'(n_lost - l0), 32'd0);

        // four errors inside the first window after lock
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        p0 = n_pulse; l0 = n_lost;
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        check("loss_lock_lost", 32'(lock_lost), 32'd1);
        check("loss_err_pulse", 32'(err_pulse), 32'd1);
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_err_count", 32'(err_count), 32'd4);
        for (int i = 0; i < 11; i++) step(1, 0, 0);
        check("relock_early", 32'(locked), 32'd0);
        step(1, 0, 0);
        check("relock_at_12", 32'(locked), 32'd1);
        check("loss_pulses", 32'(n_pulse - p0), 32'd4);
        check("loss_lost_count", 32'(n_lost - l0), 32'd1);
        check("loss_err_kept", 32'(err_count), 32'd4);

        // constant ones never lock (lockup pattern)
        do_reset();
        s0 = n_lockseen;
        for (int i = 0; i < 200; i++) raw(1, 1, 0);
        check("ones_never_lock", 32'(n_lockseen - s0), 32'd0);

        // saturation, then clear_err together with a mismatch
        do_reset();
        flips = 0;
        for (int i = 0; i < 3000 && flips < 260; i++) begin
            if (e_locked) begin step(1, 1, 0); flips++; end
            else step(1, 0, 0);
        end
        check("sat_err_count", 32'(err_count), 32'd255);
        wait_lock("sat_relock");
        step(1, 1, 1);
        check("clr_with_miss", 32'(err_count), 32'd1);
        step(0, 0, 1);
        check("clr_without_valid", 32'(err_count), 32'd0);

        // reset while locked with seven errors
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 3; i++) step(1, 1, 0);
            for (int i = 0; i < 13; i++) step(1, 0, 0);
        end
        step(1, 1, 0);
        check("pre_rst_err_count", 32'(err_count), 32'd7);
        check("pre_rst_locked", 32'(locked), 32'd1);
        l0 = n_lost;
        #3 reset = 1;
        #1;
        check("async_rst_locked", 32'(locked), 32'd0);
        check("async_rst_err_pulse", 32'(err_pulse), 32'd0);
        check("async_rst_lock_lost", 32'(lock_lost), 32'd0);
        check("async_rst_err_count", 32'(err_count), 32'd0);
        raw(0, 0, 0); raw(0, 0, 0);
        reset = 0; sidx = 0;
        raw(0, 0, 0);
        check("async_rst_no_lost", 32'(n_lost - l0), 32'd0);

        // randomized traffic with three error densities
        for (int ph = 0; ph < 3; ph++) begin
            int den;
            den = (ph == 0) ? 40 : (ph == 1) ? 12 : 4;
            for (int i = 0; i < 1200; i++) begin
                step($urandom_range(0, 9) != 0,
                     $urandom_range(0, den - 1) == 0,
                     $urandom_range(0, 149) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
